// File: rtl/sys_tx_responder.sv
// Response serializer for the system controller. Splits one 8- or 16-bit response
// into bytes for the UART TX FIFO, LSB first, and stalls while the FIFO is full.
module sys_tx_responder #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RSP_VALID,
  output logic                      RSP_READY,
  input  logic                      RSP_WIDE,
  input  logic [2*DATA_WIDTH-1:0]   RSP_DATA,
  input  logic                      FIFO_FULL,
  output logic                      FIFO_WR,
  output logic [DATA_WIDTH-1:0]     TX_DATA_OUT,
  output logic                      BUSY,
  output logic                      RSP_DONE
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEND_LO = 2'd1;
  localparam logic [1:0] SEND_HI = 2'd2;

  logic [1:0]              state;
  logic [1:0]              state_nxt;
  logic [2*DATA_WIDTH-1:0] payload;
  logic                    wide;
  logic                    accept;
  logic                    last_byte;

  assign accept = (state == IDLE) && RSP_VALID;

  // A frame completes when its final byte leaves for the FIFO on this edge.
  assign last_byte = !FIFO_FULL &&
                     (((state == SEND_LO) && !wide) || (state == SEND_HI));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      payload  <= '0;
      wide     <= 1'b0;
      RSP_DONE <= 1'b0;
    end else begin
      if (accept) begin
        payload <= RSP_DATA;
        wide    <= RSP_WIDE;
      end
      RSP_DONE <= last_byte;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = RSP_VALID ? SEND_LO : IDLE;
      SEND_LO: begin
        if (FIFO_FULL)  state_nxt = SEND_LO;
        else if (wide)  state_nxt = SEND_HI;
        else            state_nxt = IDLE;
      end
      SEND_HI: state_nxt = FIFO_FULL ? SEND_HI : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    FIFO_WR     = 1'b0;
    TX_DATA_OUT = '0;
    RSP_READY   = (state == IDLE);
    BUSY        = (state != IDLE);
    case (state)
      SEND_LO: begin
        FIFO_WR     = !FIFO_FULL;
        TX_DATA_OUT = payload[DATA_WIDTH-1:0];
      end
      SEND_HI: begin
        FIFO_WR     = !FIFO_FULL;
        TX_DATA_OUT = payload[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      default: ;
    endcase
  end

endmodule
